writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_if.sv | 36 +++
 rtl/writeback_arbiter.sv | 143 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - writeback arbiter bus: ALU/MDU result inputs, regfile write port, hazard lookup
interface writeback_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        hz1;
  logic        hz2;
  logic [2:0]  occupancy;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready,
    input  wb_we, wb_addr, wb_data,
    output rd_addr1, rd_addr2,
    input  hz1, hz2, occupancy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mdu_valid, mdu_addr, mdu_data,
    output mdu_ready,
    output wb_we, wb_addr, wb_data,
    input  rd_addr1, rd_addr2,
    output hz1, hz2, occupancy
  );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - single-port regfile writeback arbiter with MDU result FIFO
// Optional pending-write hazard lookup enabled by macro WB_HAZARD_EN.
module writeback_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                clock,
  input  logic                rst_n,
  writeback_arbiter_if.slave  bus
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_MDU
  } src_t;

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    occ_q;

  logic          wb_we_q;
  logic [4:0]    wb_addr_q;
  logic [31:0]   wb_data_q;

  src_t          src;
  logic          mdu_ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic [4:0]    win_addr;
  logic [31:0]   win_data;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy so a draining pop never opens a full buffer.
  assign mdu_ready = (occ_q < 3'(DEPTH));
  assign accept    = bus.mdu_valid && mdu_ready;

  always_comb begin
    src      = SRC_NONE;
    win_addr = '0;
    win_data = '0;
    if (bus.alu_valid) begin
      src      = SRC_ALU;
      win_addr = bus.alu_addr;
      win_data = bus.alu_data;
    end else if (occ_q != 3'd0) begin
      src      = SRC_FIFO;
      win_addr = fifo_addr[rd_ptr];
      win_data = fifo_data[rd_ptr];
    end else if (accept) begin
      src      = SRC_MDU;
      win_addr = bus.mdu_addr;
      win_data = bus.mdu_data;
    end
  end

  assign push = accept && (src != SRC_MDU);
  assign pop  = (src == SRC_FIFO);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.mdu_addr;
      fifo_data[wr_ptr] <= bus.mdu_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 3'd1;
        2'b01:   occ_q <= occ_q - 3'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Register 0 winners use up the slot but never write; address/data hold for idle cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (src != SRC_NONE && win_addr != 5'd0) begin
      wb_we_q   <= 1'b1;
      wb_addr_q <= win_addr;
      wb_data_q <= win_data;
    end else begin
      wb_we_q   <= 1'b0;
    end
  end

  assign bus.mdu_ready = mdu_ready;
  assign bus.wb_we     = wb_we_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.occupancy = occ_q;

`ifdef WB_HAZARD_EN
  logic          hz1;
  logic          hz2;
  logic [PW-1:0] idx;
  logic [PW-1:0] off;

  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    idx = '0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = PW'(i);
      off = idx - rd_ptr;
      // An entry is live when its distance from the head is below occupancy.
      if (3'(off) < occ_q) begin
        if (bus.rd_addr1 != 5'd0 && fifo_addr[idx] == bus.rd_addr1) hz1 = 1'b1;
        if (bus.rd_addr2 != 5'd0 && fifo_addr[idx] == bus.rd_addr2) hz2 = 1'b1;
      end
    end
  end

  assign bus.hz1 = hz1;
  assign bus.hz2 = hz2;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{bus.rd_addr1, bus.rd_addr2};
  assign bus.hz1 = 1'b0;
  assign bus.hz2 = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed vector bench for writeback_arbiter (DEPTH=2)
module tb_writeback_arbiter;

  logic clock;
  logic rst_n;

  writeback_arbiter_if bus();

  writeback_arbiter #(.DEPTH(2)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [2:0]  exp_occ;
    logic        exp_hz1;
    logic        exp_hz2;
  } vec_t;

  vec_t vecs[$];
  int n_applied = 0;
  int n_fail    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic er, input logic ew, input logic [4:0] ea,
                              input logic [31:0] ed, input logic [2:0] eo,
                              input logic h1, input logic h2);
    vec_t v;
    v.alu_valid = av; v.alu_addr = aa; v.alu_data = ad;
    v.mdu_valid = mv; v.mdu_addr = ma; v.mdu_data = md;
    v.rd1 = r1; v.rd2 = r2;
    v.exp_ready = er; v.exp_we = ew; v.exp_addr = ea; v.exp_data = ed;
    v.exp_occ = eo; v.exp_hz1 = h1; v.exp_hz2 = h2;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mdu_valid = mv; bus.mdu_addr = ma; bus.mdu_data = md;
  endtask

  task automatic chk_hz(input string name, input logic act, input logic exp_en);
`ifdef WB_HAZARD_EN
    chk(name, 32'(act), 32'(exp_en));
`else
    chk(name, 32'(act), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.rd_addr1 = 5'd0;
    bus.rd_addr2 = 5'd0;

    //        alu                       mdu                        rd1  rd2  rdy we addr  data           occ hz1 hz2
    vecs.push_back(mk(1, 5'd9,  32'h12345678, 0, 5'd0,  32'h0,     5'd0,  5'd0,  1, 1, 5'd9,  32'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd0,  5'd0,  1, 0, 5'd9,  32'h12345678, 0, 0, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd10, 32'hA5,    5'd0,  5'd0,  1, 1, 5'd10, 32'hA5,       0, 0, 0));
    vecs.push_back(mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,     5'd0,  5'd0,  1, 0, 5'd10, 32'hA5,       0, 0, 0));
    vecs.push_back(mk(1, 5'd1,  32'h100,      1, 5'd11, 32'hB11,   5'd11, 5'd0,  1, 1, 5'd1,  32'h100,      1, 1, 0));
    vecs.push_back(mk(1, 5'd2,  32'h200,      1, 5'd12, 32'hB12,   5'd12, 5'd11, 1, 1, 5'd2,  32'h200,      2, 1, 1));
    vecs.push_back(mk(1, 5'd3,  32'h300,      1, 5'd13, 32'hB13,   5'd13, 5'd12, 0, 1, 5'd3,  32'h300,      2, 0, 1));
    vecs.push_back(mk(1, 5'd4,  32'h400,      1, 5'd13, 32'hB13,   5'd0,  5'd0,  0, 1, 5'd4,  32'h400,      2, 0, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd13, 32'hB13,   5'd11, 5'd12, 0, 1, 5'd11, 32'hB11,      1, 0, 1));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd13, 32'hB13,   5'd13, 5'd12, 1, 1, 5'd12, 32'hB12,      1, 1, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd13, 5'd0,  1, 1, 5'd13, 32'hB13,      0, 0, 0));
    vecs.push_back(mk(1, 5'd5,  32'h500,      1, 5'd0,  32'hDEAD,  5'd0,  5'd0,  1, 1, 5'd5,  32'h500,      1, 0, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd14, 32'hE14,   5'd14, 5'd0,  1, 0, 5'd5,  32'h500,      1, 1, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd15, 32'hF15,   5'd15, 5'd14, 1, 1, 5'd14, 32'hE14,      1, 1, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd15, 5'd0,  1, 1, 5'd15, 32'hF15,      0, 0, 0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd0,  5'd0,  1, 0, 5'd15, 32'hF15,      0, 0, 0));

    // Reset state, asserted from time zero.
    #3;
    chk("rst_wb_we",   32'(bus.wb_we),     32'd0);
    chk("rst_wb_addr", 32'(bus.wb_addr),   32'd0);
    chk("rst_wb_data", bus.wb_data,        32'd0);
    chk("rst_occ",     32'(bus.occupancy), 32'd0);
    chk("rst_ready",   32'(bus.mdu_ready), 32'd1);
    chk("rst_hz1",     32'(bus.hz1),       32'd0);
    chk("rst_hz2",     32'(bus.hz2),       32'd0);
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].alu_valid, vecs[i].alu_addr, vecs[i].alu_data,
            vecs[i].mdu_valid, vecs[i].mdu_addr, vecs[i].mdu_data);
      bus.rd_addr1 = vecs[i].rd1;
      bus.rd_addr2 = vecs[i].rd2;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.mdu_ready), 32'(vecs[i].exp_ready));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_we", i),   32'(bus.wb_we),     32'(vecs[i].exp_we));
      chk($sformatf("v%0d_addr", i), 32'(bus.wb_addr),   32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_data", i), bus.wb_data,        vecs[i].exp_data);
      chk($sformatf("v%0d_occ", i),  32'(bus.occupancy), 32'(vecs[i].exp_occ));
      chk_hz($sformatf("v%0d_hz1", i), bus.hz1, vecs[i].exp_hz1);
      chk_hz($sformatf("v%0d_hz2", i), bus.hz2, vecs[i].exp_hz2);
      @(negedge clock);
    end

    // Fill the buffer behind ALU traffic, then reset asynchronously between edges.
    drive(1'b1, 5'd6, 32'h600, 1'b1, 5'd20, 32'h2020);
    @(posedge clock);
    @(negedge clock);
    drive(1'b1, 5'd7, 32'h700, 1'b1, 5'd21, 32'h2121);
    @(posedge clock);
    #1;
    chk("fill_occ",  32'(bus.occupancy), 32'd2);
    chk("fill_addr", 32'(bus.wb_addr),   32'd7);
    #2;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("arst_occ",   32'(bus.occupancy), 32'd0);
    chk("arst_we",    32'(bus.wb_we),     32'd0);
    chk("arst_addr",  32'(bus.wb_addr),   32'd0);
    chk("arst_data",  bus.wb_data,        32'd0);
    chk("arst_ready", 32'(bus.mdu_ready), 32'd1);
    @(posedge clock);
    #1;
    chk("hold_rst_ready", 32'(bus.mdu_ready), 32'd1);
    chk("hold_rst_we",    32'(bus.wb_we),     32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("post_rst%0d_we", k),    32'(bus.wb_we),     32'd0);
      chk($sformatf("post_rst%0d_occ", k),   32'(bus.occupancy), 32'd0);
      chk($sformatf("post_rst%0d_ready", k), 32'(bus.mdu_ready), 32'd1);
    end

    // First update after reset release lands on the next edge.
    @(negedge clock);
    drive(1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 32'd0);
    @(posedge clock);
    #1;
    chk("rel_we",   32'(bus.wb_we),   32'd1);
    chk("rel_addr", 32'(bus.wb_addr), 32'd9);
    chk("rel_data", bus.wb_data,      32'h12345678);
    @(negedge clock);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clock);
    #1;
    chk("rel_we_off", 32'(bus.wb_we), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
